// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage constants, state encoding and buffer entry type
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small synchronous FIFO of fetched {pc_plus4, instr} entries
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       clear,
    output fetch_entry_t               head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         full;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d                = wr_ptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, single-outstanding imem requests, instruction buffer
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCPlus4_IF,
    output logic [31:0] Instr_IF,
    output logic        if_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW + 2)'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;

    logic          push, pop, room, issue;
    logic [AW+1:0] occ_after;
    fetch_entry_t  push_data, head;
    logic [AW:0]   buf_count;
    logic          buf_empty;

    always_comb begin
        push = (state_q == WAIT) && imem_rvalid && !redirect;
        pop  = !stall && !buf_empty && !redirect;

        // While WAIT, fetch_pc_q already holds the outstanding request's address + 4.
        push_data.pc_plus4 = fetch_pc_q;
        push_data.instr    = imem_rdata;

        occ_after = {1'b0, buf_count}
                  + {{(AW + 1){1'b0}}, push}
                  - {{(AW + 1){1'b0}}, pop};
        room  = (occ_after < DEPTH_W);
        issue = rst_n && !redirect && room &&
                ((state_q == IDLE) || ((state_q == WAIT) && imem_rvalid));

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: if (issue) state_d = WAIT;
            WAIT: begin
                if (redirect)         state_d = imem_rvalid ? IDLE : DROP;
                else if (imem_rvalid) state_d = issue ? WAIT : IDLE;
            end
            DROP: if (imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (redirect)   fetch_pc_d = word_align(redirect_pc);
        else if (issue) fetch_pc_d = fetch_pc_q + 32'd4;

        imem_req   = issue;
        imem_addr  = fetch_pc_q;
        if_valid   = !buf_empty;
        Instr_IF   = buf_empty ? NOP_INSTR : head.instr;
        PCPlus4_IF = buf_empty ? 32'h0     : head.pc_plus4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_buffer #(
        .DEPTH(DEPTH)
    ) u_fetch_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (redirect),
        .head_data (head),
        .count     (buf_count),
        .empty     (buf_empty)
    );

endmodule
